// File: rtl/multdiv_pkg.sv
// Shared types, constants and two's-complement helpers for the multdiv unit.
package multdiv_pkg;

  localparam int unsigned WIDTH          = 32;
  localparam int unsigned DIV_ITERATIONS = 32;
  localparam int unsigned DIV_CNT_W      = $clog2(DIV_ITERATIONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement negate.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Magnitude as an unsigned WIDTH-bit value; |-2^(WIDTH-1)| maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] twos_abs(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring step: shift in the next dividend bit, then add or
// subtract the divisor depending on the sign of the old partial remainder.
module div_step
  import multdiv_pkg::*;
(
  input  logic [WIDTH:0] acc,
  input  logic           q_in,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] acc_next_c,
  output logic           q_bit_c
);

  logic [WIDTH:0] acc_sh;

  // Partial remainder stays within [-M, M), so bit WIDTH is redundant with bit WIDTH-1 before the shift.
  always_comb begin
    acc_sh     = {acc[WIDTH-1:0], q_in};
    acc_next_c = acc[WIDTH] ? (acc_sh + m) : (acc_sh - m);
    q_bit_c    = ~acc_next_c[WIDTH];
  end

endmodule

// File: rtl/div_control.sv
// Sequential signed divider: 32 non-restoring iterations, one sign-fixup cycle,
// results presented with a one-cycle ready pulse.
// Optional feature macro: DIV_REMAINDER_EN (remainder port, restore and sign fix).
module div_control
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             ready,
  output logic             busy,
  output logic             exception
);

  div_state_e           state;
  logic [DIV_CNT_W-1:0] count;
  logic [WIDTH:0]       acc;
  logic [WIDTH-1:0]     q;
  logic [WIDTH:0]       m;
  logic                 neg_quot;
  logic [WIDTH:0]       step_acc_c;
  logic                 step_q_c;

`ifdef DIV_REMAINDER_EN
  logic                 neg_rem;
  logic [WIDTH:0]       acc_fix_c;

  // Restore a negative final partial remainder.
  always_comb begin
    acc_fix_c = acc[WIDTH] ? (acc + m) : acc;
  end
`endif

  div_step u_step (
    .acc        (acc),
    .q_in       (q[WIDTH-1]),
    .m          (m),
    .acc_next_c (step_acc_c),
    .q_bit_c    (step_q_c)
  );

  // Control FSM, iteration counter, datapath and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      neg_quot  <= 1'b0;
      quotient  <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
      neg_rem   <= 1'b0;
      remainder <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state     <= DONE;
              exception <= 1'b1;
              quotient  <= '0;
              ready     <= 1'b1;
`ifdef DIV_REMAINDER_EN
              remainder <= dividend;
`endif
            end else begin
              state    <= ITER;
              busy     <= 1'b1;
              neg_quot <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              m        <= {1'b0, twos_abs(divisor)};
              q        <= twos_abs(dividend);
              acc      <= '0;
              count    <= '0;
`ifdef DIV_REMAINDER_EN
              neg_rem  <= dividend[WIDTH-1];
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          acc   <= step_acc_c;
          q     <= {q[WIDTH-2:0], step_q_c};
          count <= count + DIV_CNT_W'(1);
          if (count == DIV_CNT_W'(DIV_ITERATIONS - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= neg_quot ? twos_neg(q) : q;
          exception <= 1'b0;
          ready     <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
`ifdef DIV_REMAINDER_EN
          acc       <= acc_fix_c;
          remainder <= neg_rem ? twos_neg(acc_fix_c[WIDTH-1:0]) : acc_fix_c[WIDTH-1:0];
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
